// File: rtl/ps2_scan_rx_if.sv
// rtl/ps2_scan_rx_if.sv - PS/2 line inputs and decoded scancode outputs of the receiver
interface ps2_scan_rx_if;
  logic       enable_rcv;
  logic       ps2clk_in;
  logic       ps2data_in;
  logic       scan_received;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       rx_error;
  logic       busy;

  modport slave (
    input  enable_rcv, ps2clk_in, ps2data_in,
    output scan_received, scancode, extended, released, rx_error, busy
  );

  modport master (
    output enable_rcv, ps2clk_in, ps2data_in,
    input  scan_received, scancode, extended, released, rx_error, busy
  );
endinterface

// File: rtl/ps2_scan_rx.sv
// rtl/ps2_scan_rx.sv - PS/2 keyboard frame receiver with E0/F0 prefix decoding
module ps2_scan_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic           clk,
  input  logic           rst,
  ps2_scan_rx_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic       clk_s1, clk_s2, data_s1, data_s2;
  logic       filt, filt_prev;
  logic [3:0] fcnt;
  logic       fall, clk_edge;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       parity_odd;
  logic       ext_pending, rls_pending;
  logic [15:0] tcnt;

  logic [7:0] scancode_q;
  logic       extended_q, released_q, scan_received_q, rx_error_q;

  // Synchronizers and glitch filter idle high, matching an idle PS/2 bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      data_s1   <= 1'b1;
      data_s2   <= 1'b1;
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      fcnt      <= '0;
    end else begin
      clk_s1    <= bus.ps2clk_in;
      clk_s2    <= clk_s1;
      data_s1   <= bus.ps2data_in;
      data_s2   <= data_s1;
      filt_prev <= filt;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == 4'(FILTER_LEN - 1)) begin
        filt <= clk_s2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 4'd1;
      end
    end
  end

  assign fall     = filt_prev & ~filt;
  assign clk_edge = filt_prev ^ filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shreg           <= '0;
      parity_odd      <= 1'b0;
      ext_pending     <= 1'b0;
      rls_pending     <= 1'b0;
      tcnt            <= '0;
      scancode_q      <= '0;
      extended_q      <= 1'b0;
      released_q      <= 1'b0;
      scan_received_q <= 1'b0;
      rx_error_q      <= 1'b0;
    end else begin
      scan_received_q <= 1'b0;
      rx_error_q      <= 1'b0;

      if (state == IDLE || clk_edge) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (fall && !data_s2 && bus.enable_rcv) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (fall) begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            parity_odd <= ^{shreg, data_s2};
            state      <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state <= IDLE;
            if (parity_odd && data_s2) begin
              if (shreg == 8'hE0) begin
                ext_pending <= 1'b1;
              end else if (shreg == 8'hF0) begin
                rls_pending <= 1'b1;
              end else begin
                scancode_q      <= shreg;
                extended_q      <= ext_pending;
                released_q      <= rls_pending;
                scan_received_q <= 1'b1;
                ext_pending     <= 1'b0;
                rls_pending     <= 1'b0;
              end
            end else begin
              rx_error_q  <= 1'b1;
              ext_pending <= 1'b0;
              rls_pending <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A stalled frame is abandoned; an edge in the same cycle keeps it alive.
      if (state != IDLE && !clk_edge && tcnt == 16'(TIMEOUT_CYCLES)) begin
        state       <= IDLE;
        shreg       <= '0;
        rx_error_q  <= 1'b1;
        ext_pending <= 1'b0;
        rls_pending <= 1'b0;
      end
    end
  end

  assign bus.scan_received = scan_received_q;
  assign bus.rx_error      = rx_error_q;
  assign bus.scancode      = scancode_q;
  assign bus.extended      = extended_q;
  assign bus.released      = released_q;
  assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb/tb_ps2_scan_rx.sv - self-checking bench for ps2_scan_rx
module tb_ps2_scan_rx;
  localparam int FL = 4;
  localparam int TO = 200;
  localparam int H  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_scan_rx_if bus ();

  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int scan_cnt = 0, err_cnt = 0, overlap_cnt = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.scan_received) scan_cnt++;
      if (bus.rx_error) err_cnt++;
      if (bus.scan_received && bus.rx_error) overlap_cnt++;
      if (bus.busy) busy_cnt++;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.ps2data_in = b;
    repeat (H / 2) @(negedge clk);
    bus.ps2clk_in = 1'b0;
    repeat (H) @(negedge clk);
    bus.ps2clk_in = 1'b1;
    repeat (H / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    send_bit(~bad_stop);
    bus.ps2data_in = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(b[i]);
    bus.ps2data_in = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       bad_stop;
    int         exp_scan;
    int         exp_err;
    logic [7:0] exp_code;
    logic       exp_ext;
    logic       exp_rel;
  } vec_t;

  vec_t vecs[13];

  // Reference model state for the randomized phase
  logic [7:0] m_code;
  logic       m_ext, m_rel, m_ext_p, m_rel_p;
  int         m_scan, m_err;

  initial begin
    int s0, e0, b0;
    bus.enable_rcv = 1'b1;
    bus.ps2clk_in  = 1'b1;
    bus.ps2data_in = 1'b1;

    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[1]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[3]  = '{8'h74, 1'b0, 1'b0, 1, 0, 8'h74, 1'b1, 1'b1};
    vecs[4]  = '{8'h1C, 1'b0, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[5]  = '{8'h1C, 1'b1, 1'b0, 0, 1, 8'h1C, 1'b0, 1'b0};
    vecs[6]  = '{8'hE0, 1'b0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[7]  = '{8'h5A, 1'b0, 1'b1, 0, 1, 8'h1C, 1'b0, 1'b0};
    vecs[8]  = '{8'h5A, 1'b0, 1'b0, 1, 0, 8'h5A, 1'b0, 1'b0};
    vecs[9]  = '{8'hAA, 1'b0, 1'b0, 1, 0, 8'hAA, 1'b0, 1'b0};
    vecs[10] = '{8'hF0, 1'b0, 1'b0, 0, 0, 8'hAA, 1'b0, 1'b0};
    vecs[11] = '{8'hFA, 1'b0, 1'b0, 1, 0, 8'hFA, 1'b0, 1'b1};
    vecs[12] = '{8'hE1, 1'b0, 1'b0, 1, 0, 8'hE1, 1'b0, 1'b0};

    do_reset();
    check("reset_scancode", int'(bus.scancode), 0);
    check("reset_extended", int'(bus.extended), 0);
    check("reset_released", int'(bus.released), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_pulses", scan_cnt + err_cnt, 0);

    foreach (vecs[i]) begin
      s0 = scan_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
      check($sformatf("vec%0d_scan", i), scan_cnt - s0, vecs[i].exp_scan);
      check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("vec%0d_code", i), int'(bus.scancode), int'(vecs[i].exp_code));
      check($sformatf("vec%0d_ext", i), int'(bus.extended), int'(vecs[i].exp_ext));
      check($sformatf("vec%0d_rel", i), int'(bus.released), int'(vecs[i].exp_rel));
      check($sformatf("vec%0d_busy", i), int'(bus.busy), 0);
    end

    // Timeout: pending E0 then a stalled frame; the E0 must not leak into the next byte
    send_frame(8'hE0, 1'b0, 1'b0);
    s0 = scan_cnt;
    e0 = err_cnt;
    send_partial(8'h55, 4);
    check("timeout_busy_during", int'(bus.busy), 1);
    repeat (TO + FL + 4) @(negedge clk);
    repeat (8) @(negedge clk);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_scan", scan_cnt - s0, 0);
    check("timeout_busy", int'(bus.busy), 0);
    s0 = scan_cnt;
    send_frame(8'h29, 1'b0, 1'b0);
    check("after_timeout_scan", scan_cnt - s0, 1);
    check("after_timeout_code", int'(bus.scancode), 8'h29);
    check("after_timeout_ext", int'(bus.extended), 0);

    // Clock glitch just below the filter length, with data low to look like a start bit
    b0 = busy_cnt;
    bus.ps2data_in = 1'b0;
    bus.ps2clk_in = 1'b0;
    repeat (FL - 1) @(negedge clk);
    bus.ps2clk_in = 1'b1;
    repeat (20) @(negedge clk);
    bus.ps2data_in = 1'b1;
    repeat (4) @(negedge clk);
    check("glitch_busy", busy_cnt - b0, 0);
    check("glitch_code", int'(bus.scancode), 8'h29);

    // Receiver held off for a whole frame
    b0 = busy_cnt;
    s0 = scan_cnt;
    e0 = err_cnt;
    bus.enable_rcv = 1'b0;
    send_frame(8'h3A, 1'b0, 1'b0);
    bus.enable_rcv = 1'b1;
    check("disabled_pulses", (scan_cnt - s0) + (err_cnt - e0), 0);
    check("disabled_busy", busy_cnt - b0, 0);

    // Reset in the middle of a frame
    s0 = scan_cnt;
    e0 = err_cnt;
    send_partial(8'h5B, 3);
    do_reset();
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_code", int'(bus.scancode), 0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("midrst_scan", scan_cnt - s0, 1);
    check("midrst_err", err_cnt - e0, 0);
    check("midrst_code2", int'(bus.scancode), 8'h1C);

    // Randomized frames against a byte-level model of the prefix rules
    do_reset();
    m_code = 8'h00; m_ext = 1'b0; m_rel = 1'b0;
    m_ext_p = 1'b0; m_rel_p = 1'b0;
    m_scan = 0; m_err = 0;
    s0 = scan_cnt;
    e0 = err_cnt;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      int sel, ek;
      sel = $urandom_range(0, 5);
      b = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      ek = $urandom_range(0, 7);
      send_frame(b, ek == 0, ek == 1);
      if (ek <= 1) begin
        m_err++;
        m_ext_p = 1'b0;
        m_rel_p = 1'b0;
      end else if (b == 8'hE0) begin
        m_ext_p = 1'b1;
      end else if (b == 8'hF0) begin
        m_rel_p = 1'b1;
      end else begin
        m_scan++;
        m_code = b;
        m_ext = m_ext_p;
        m_rel = m_rel_p;
        m_ext_p = 1'b0;
        m_rel_p = 1'b0;
      end
      check($sformatf("rand%0d_scan", n), scan_cnt - s0, m_scan);
      check($sformatf("rand%0d_err", n), err_cnt - e0, m_err);
      check($sformatf("rand%0d_code", n), int'(bus.scancode), int'(m_code));
      check($sformatf("rand%0d_ext", n), int'(bus.extended), int'(m_ext));
      check($sformatf("rand%0d_rel", n), int'(bus.released), int'(m_rel));
    end

    check("no_overlap", overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples needed to change the filtered PS/2 clock level (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: clk cycles without a filtered PS/2 clock edge before a frame is aborted (1..65535).
REQ-003 SHALL have port clk, input, 1: system clock; one clock domain, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port enable_rcv, input, 1: 1 = new frames may start; 0 = receiver held off while the host transmits.
REQ-006 SHALL have port ps2clk_in, input, 1: raw PS/2 clock line, asynchronous.
REQ-007 SHALL have port ps2data_in, input, 1: raw PS/2 data line, asynchronous.
REQ-008 SHALL have port scan_received, output, 1: one-cycle pulse marking a new complete scancode.
REQ-009 SHALL have port scancode, output, 8: last non-prefix byte received.
REQ-010 SHALL have port extended, output, 1: an E0 prefix preceded scancode.
REQ-011 SHALL have port released, output, 1: an F0 prefix preceded scancode.
REQ-012 SHALL have port rx_error, output, 1: one-cycle pulse on a parity, stop-bit or timeout error.
REQ-013 SHALL have port busy, output, 1: high whenever the state machine is not IDLE.

Function
REQ-014 SHALL pass each of ps2clk_in and ps2data_in through a 2-flop synchronizer before any use.
REQ-015 SHALL filter the synchronized clock: filtered level goes to 0 after FILTER_LEN consecutive 0 samples and to 1 after FILTER_LEN consecutive 1 samples, otherwise holds; filtered level resets to 1.
REQ-016 SHALL define a sample event as a 1->0 transition of the filtered clock, with data taken from the synchronized data line in that same cycle.
REQ-017 SHALL implement the states IDLE, DATA, PARITY and STOP.
REQ-018 SHALL move from IDLE to DATA, with bit count 0, on a sample event with data=0 and enable_rcv=1; a sample event with data=1 or enable_rcv=0 leaves it in IDLE.
REQ-019 SHALL sample enable_rcv only in IDLE; a frame already in progress completes regardless of enable_rcv.
REQ-020 SHALL shift 8 data bits LSB-first in DATA, one per sample event, then go to PARITY.
REQ-021 SHALL, in PARITY, record whether the 8 data bits plus the parity bit contain an odd number of ones, then go to STOP.
REQ-022 SHALL, in STOP, on the sample event, return to IDLE and process the frame; the frame is valid only if parity was odd and the stop bit is 1.
REQ-023 SHALL handle a valid byte 0xE0 by setting ext_pending, with no pulse.
REQ-024 SHALL handle a valid byte 0xF0 by setting rls_pending, with no pulse.
REQ-025 SHALL handle any other valid byte by loading scancode=byte, extended=ext_pending and released=rls_pending, pulsing scan_received and clearing both pending flags.
REQ-026 SHALL handle an invalid frame by pulsing rx_error, clearing both pending flags and leaving scancode, extended and released unchanged.
REQ-027 SHALL clear the timeout counter on every filtered-clock edge and while in IDLE.
REQ-028 SHALL, outside IDLE, when the timeout counter reaches TIMEOUT_CYCLES, return to IDLE, pulse rx_error, clear both pending flags and discard the partial byte.
REQ-029 SHALL make scan_received and rx_error each high for exactly one cycle, the cycle after the stop-bit sample event (or after the timeout cycle); the two are never high together.
REQ-030 SHALL hold scancode, extended and released stable between pulses.
REQ-031 SHALL pass bytes such as 0xAA, 0xFA and 0xE1 through as ordinary scancodes.

Reset
REQ-032 SHALL, on rst=1, set state=IDLE, scancode=0x00, extended=0, released=0, scan_received=0, rx_error=0, busy=0, both pending flags=0, counters=0, synchronizer and filter flops=1.
REQ-033 SHALL let rst abort a frame mid-reception with no pulse, so that the next full frame after rst is received normally.

Verification
REQ-034 SHALL be verified with frame 0x1C (parity 0, stop 1) -> one scan_received pulse, scancode=0x1C, extended=0, released=0, busy back to 0.
REQ-035 SHALL be verified with frames E0, F0, 74 -> exactly one scan_received pulse (after 74), scancode=0x74, extended=1, released=1; a following 0x1C frame gives extended=0, released=0.
REQ-036 SHALL be verified with frame 0x1C carrying parity bit 1 -> rx_error pulse, no scan_received, scancode unchanged.
REQ-037 SHALL be verified with 4 data bits then ps2clk held high for TIMEOUT_CYCLES+FILTER_LEN+4 cycles -> one rx_error pulse, busy=0, next valid frame 0x29 decoded correctly.
REQ-038 SHALL be verified with a low glitch of FILTER_LEN-1 cycles on ps2clk in IDLE -> no state change, busy stays 0.
REQ-039 SHALL be verified with enable_rcv=0 during a whole frame -> no pulses; and with rst asserted after bit 3, then frame 0x1C -> scancode=0x1C.
